// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable sequence detector: FSM encodings,
// length-field width calculation and the saturating-increment helper.
package seq_det_pkg;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_HUNT = 2'd2;

    // Width needed to hold the values 0..max_len inclusive.
    function automatic int seq_det_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Counters up to 64 bits wide are zero-extended into this helper.
    function automatic logic [63:0] seq_det_sat_inc(input logic [63:0] val,
                                                    input logic [63:0] max_val);
        return (val == max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating event counter: increments on inc, sticks at all-ones, clr has priority.
// Result visible the cycle after the edge; no backpressure.
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [63:0] MAX_V = 64'({CNT_W{1'b1}});

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= CNT_W'(seq_det_sat_inc(64'(r_cnt), MAX_V));
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector; match is registered (1 cycle after the bit), no backpressure.
// Define SEQ_DET_MASK_EN to add cfg_mask, which turns pattern positions into don't-cares.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = seq_det_len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_wr,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_ovl,
`ifdef SEQ_DET_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_fill;
    logic               r_ovl;
    logic               r_match;
    logic [1:0]         r_state;
`ifdef SEQ_DET_MASK_EN
    logic [MAX_LEN-1:0] r_mask;
`endif

    logic [MAX_LEN-1:0] w_hist_next;
    logic [MAX_LEN-1:0] w_len_mask;
    logic [MAX_LEN-1:0] w_diff;
    logic [LEN_W-1:0]   w_fill_next;
    logic [LEN_W-1:0]   w_len_clamp;
    logic               w_accept;
    logic               w_eligible;
    logic               w_hit;

    // A config write in the same cycle as a valid bit drops the bit.
    assign w_accept    = in_valid & ~cfg_wr;
    assign w_hist_next = {r_hist[MAX_LEN-2:0], in_bit};
    assign w_fill_next = (r_fill == LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
    assign w_len_clamp = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (i < int'(r_len));
        end
    end

`ifdef SEQ_DET_MASK_EN
    assign w_diff = (w_hist_next ^ r_pat) & w_len_mask & ~r_mask;
`else
    assign w_diff = (w_hist_next ^ r_pat) & w_len_mask;
`endif

    // The bit that completes the fill is compared on the same edge it arrives.
    assign w_eligible = (r_state == ST_HUNT) ||
                        ((r_state == ST_FILL) && (w_fill_next >= r_len));
    assign w_hit      = w_accept & w_eligible & ~|w_diff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat   <= '0;
            r_len   <= '0;
            r_ovl   <= 1'b1;
            r_hist  <= '0;
            r_fill  <= '0;
            r_state <= ST_OFF;
            r_match <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            r_mask  <= '0;
`endif
        end else begin
            r_match <= w_hit;
            if (cfg_wr) begin
                r_pat   <= cfg_pat;
                r_len   <= w_len_clamp;
                r_ovl   <= cfg_ovl;
`ifdef SEQ_DET_MASK_EN
                r_mask  <= cfg_mask;
`endif
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= (w_len_clamp == '0) ? ST_OFF : ST_FILL;
            end else if (in_valid) begin
                r_hist <= w_hist_next;
                r_fill <= w_fill_next;
                if (w_hit && !r_ovl) begin
                    // Non-overlapping: restart the fill so matched bits are not reused.
                    r_fill  <= '0;
                    r_state <= (r_len > LEN_W'(1)) ? ST_FILL : ST_HUNT;
                end else if ((r_state == ST_FILL) && (w_fill_next >= r_len)) begin
                    r_state <= ST_HUNT;
                end
            end
        end
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_hit),
        .cnt (match_cnt)
    );

    assign match = r_match;
    assign armed = (r_state == ST_HUNT);

endmodule
